// File: rtl/mac_accum16.sv
// mac_accum16: unsigned accumulator for 16-bit product beats. Presents the
// completed sum, beat count and sticky overflow on a held, registered result port.
module mac_accum16 #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic S_ACC  = 1'b0;
  localparam logic S_HOLD = 1'b1;

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_acc_d;
  logic [CNT_W-1:0] out_cnt_d;
  logic             out_ovf_d;

  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             in_fire_c;

  assign in_ready  = (state_q == S_ACC) || out_ready;
  assign out_valid = (state_q == S_HOLD);
  assign in_fire_c = in_valid && in_ready;

  // Internal acc is always zero while holding, so a beat taken alongside the
  // result naturally starts the next accumulation from 0.
  assign sum_c     = {1'b0, acc_q} + SUM_W'(in_prod);
  assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_acc_d = out_acc;
    out_cnt_d = out_cnt;
    out_ovf_d = out_ovf;

    case (state_q)
      S_ACC:   state_d = S_ACC;
      S_HOLD:  if (out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase

    if (in_fire_c) begin
      if (in_last) begin
        out_acc_d = sum_c[ACC_W-1:0];
        out_cnt_d = cnt_inc_c;
        out_ovf_d = ovf_q | sum_c[ACC_W];
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        state_d   = S_HOLD;
      end else begin
        acc_d = sum_c[ACC_W-1:0];
        cnt_d = cnt_inc_c;
        ovf_d = ovf_q | sum_c[ACC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      out_acc <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      out_acc <= out_acc_d;
      out_cnt <= out_cnt_d;
      out_ovf <= out_ovf_d;
    end
  end

endmodule
